// File: rtl/vtc_pkg.sv
// Shared types and helpers for the variable-to-check LLR cell.
// Optional feature macro: VTC_SAT_EN (saturating LLR input path).
package vtc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Circular address: (c + off) mod z, given both operands are already below z.
  // The sum carries one extra bit so that it cannot overflow before the compare.
  function automatic logic [31:0] mod_add(input logic [31:0] c,
                                          input logic [31:0] off,
                                          input logic [31:0] z);
    logic [32:0] s;
    s = {1'b0, c} + {1'b0, off};
    if (s >= {1'b0, z}) s = s - {1'b0, z};
    return s[31:0];
  endfunction

  // Clamp a signed value into the signed range of a dw-bit word.
  function automatic logic signed [31:0] sat_llr(input logic signed [31:0] x,
                                                 input int dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/vtc_rd_agen.sv
// READ-phase address generator: walks c (inner, 0..Z-1) and e (outer edge
// index) and emits (c + offset[e]) mod Z with the rate-selected offset table.
module vtc_rd_agen
  import vtc_pkg::*;
#(
  parameter int A_WID     = 8,
  parameter int Z         = 64,
  parameter int NUM_EDGES = 4,
  parameter logic [NUM_EDGES*A_WID-1:0] OFFSETS_R0 = '0,
  parameter logic [NUM_EDGES*A_WID-1:0] OFFSETS_R1 = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             rate_i,
  input  logic             active_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic             rd_en_o,
  output logic [A_WID-1:0] rd_addr_o,
  output logic [3:0]       rd_edge_o,
  output logic             rd_last_o,
  output logic             final_o
);

  logic [A_WID-1:0] c_q, c_d;
  logic [3:0]       e_q, e_d;
  logic             rate_q, rate_d;
  logic             rd_en_d, rd_last_d;
  logic [A_WID-1:0] rd_addr_d;
  logic [3:0]       rd_edge_d;

  // Offset tables padded to 16 entries so the 4-bit edge counter indexes them directly.
  logic [A_WID-1:0] off_r0 [16];
  logic [A_WID-1:0] off_r1 [16];

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_off
    if (gi < NUM_EDGES) begin : g_used
      assign off_r0[gi] = OFFSETS_R0[gi*A_WID +: A_WID];
      assign off_r1[gi] = OFFSETS_R1[gi*A_WID +: A_WID];
      if ((OFFSETS_R0[gi*A_WID +: A_WID] >= Z) || (OFFSETS_R1[gi*A_WID +: A_WID] >= Z)) begin : g_bad
        $fatal(1, "vtc_rd_agen: every edge offset must be below Z");
      end
    end else begin : g_unused
      assign off_r0[gi] = '0;
      assign off_r1[gi] = '0;
    end
  end

  logic [A_WID-1:0] cur_off;
  logic             issue, c_last, e_last;

  assign cur_off = rate_q ? off_r1[e_q] : off_r0[e_q];
  assign issue   = active_i & ~stall_i;
  assign c_last  = (c_q == A_WID'(Z - 1));
  assign e_last  = (e_q == 4'(NUM_EDGES - 1));
  assign final_o = issue & c_last & e_last & ~abort_i;

  // Next-state: abort clears, start latches the rate, each unstalled cycle issues one read.
  always_comb begin
    c_d       = c_q;
    e_d       = e_q;
    rate_d    = rate_q;
    rd_en_d   = 1'b0;
    rd_last_d = 1'b0;
    rd_addr_d = rd_addr_o;
    rd_edge_d = rd_edge_o;
    if (abort_i) begin
      c_d       = '0;
      e_d       = '0;
      rate_d    = 1'b0;
      rd_addr_d = '0;
      rd_edge_d = '0;
    end else if (start_i) begin
      c_d    = '0;
      e_d    = '0;
      rate_d = rate_i;
    end else if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = A_WID'(mod_add(32'(c_q), 32'(cur_off), 32'(Z)));
      rd_edge_d = e_q;
      rd_last_d = c_last & e_last;
      if (c_last) begin
        c_d = '0;
        e_d = e_last ? 4'd0 : e_q + 4'd1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q       <= '0;
      e_q       <= '0;
      rate_q    <= 1'b0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_edge_o <= '0;
      rd_last_o <= 1'b0;
    end else begin
      c_q       <= c_d;
      e_q       <= e_d;
      rate_q    <= rate_d;
      rd_en_o   <= rd_en_d;
      rd_addr_o <= rd_addr_d;
      rd_edge_o <= rd_edge_d;
      rd_last_o <= rd_last_d;
    end
  end

endmodule

// File: rtl/vtc_cell_qc.sv
// Variable-to-check LLR cell for QC-LDPC: LOAD writes Z channel LLRs into the
// variable-node RAM, READ emits circularly shifted read addresses per edge.
// Optional feature macro: VTC_SAT_EN (llr_data is D_WID+2 bits signed and is
// saturated to the D_WID signed range before being written).
module vtc_cell_qc
  import vtc_pkg::*;
#(
  parameter int D_WID     = 8,
  parameter int A_WID     = 8,
  parameter int Z         = 64,
  parameter int NUM_EDGES = 4,
  parameter logic [NUM_EDGES*A_WID-1:0] OFFSETS_R0 = '0,
  parameter logic [NUM_EDGES*A_WID-1:0] OFFSETS_R1 = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rate,
  input  logic             load_start,
  input  logic             read_start,
  input  logic             abort,
  input  logic             llr_valid,
  output logic             llr_ready,
`ifdef VTC_SAT_EN
  input  logic [D_WID+1:0] llr_data,
`else
  input  logic [D_WID-1:0] llr_data,
`endif
  output logic             ram_wr,
  output logic [A_WID-1:0] wr_addr,
  output logic [D_WID-1:0] ram_d,
  input  logic             rd_stall,
  output logic             rd_en,
  output logic [A_WID-1:0] rd_addr,
  output logic [3:0]       rd_edge,
  output logic             rd_last,
  output logic             busy,
  output logic             done
);

  localparam int Z_BITS = clog2(Z);

  if ((Z < 2) || (Z_BITS > A_WID)) begin : g_bad_z
    $fatal(1, "vtc_cell_qc: Z must satisfy 2 <= Z <= 2**A_WID");
  end
  if ((NUM_EDGES < 1) || (NUM_EDGES > 16)) begin : g_bad_edges
    $fatal(1, "vtc_cell_qc: NUM_EDGES must be within 1..16");
  end

  state_t           state_q, state_d;
  logic [A_WID-1:0] load_cnt_q, load_cnt_d;
  logic             ram_wr_d, done_d;
  logic [A_WID-1:0] wr_addr_d;
  logic [D_WID-1:0] ram_d_d;
  logic [D_WID-1:0] llr_word;
  logic             accept, rd_start, rd_final;

`ifdef VTC_SAT_EN
  assign llr_word = D_WID'(sat_llr(32'($signed(llr_data)), D_WID));
`else
  assign llr_word = llr_data;
`endif

  assign llr_ready = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign accept    = llr_valid & llr_ready;
  assign rd_start  = (state_q == IDLE) & read_start & ~load_start & ~abort;

  vtc_rd_agen #(
    .A_WID      (A_WID),
    .Z          (Z),
    .NUM_EDGES  (NUM_EDGES),
    .OFFSETS_R0 (OFFSETS_R0),
    .OFFSETS_R1 (OFFSETS_R1)
  ) u_agen (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (rd_start),
    .rate_i    (rate),
    .active_i  (state_q == READ),
    .stall_i   (rd_stall),
    .abort_i   (abort),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_edge_o (rd_edge),
    .rd_last_o (rd_last),
    .final_o   (rd_final)
  );

  // FSM and load path next-state; abort overrides everything and suppresses done.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    ram_wr_d   = 1'b0;
    wr_addr_d  = wr_addr;
    ram_d_d    = ram_d;
    done_d     = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      load_cnt_d = '0;
      wr_addr_d  = '0;
      ram_d_d    = '0;
    end else begin
      // READ completion: done trails the registered rd_last by one cycle.
      done_d = rd_last;
      unique case (state_q)
        IDLE: begin
          if (load_start) begin
            state_d    = LOAD;
            load_cnt_d = '0;
          end else if (read_start) begin
            state_d = READ;
          end
        end
        LOAD: begin
          if (accept) begin
            ram_wr_d  = 1'b1;
            wr_addr_d = load_cnt_q;
            ram_d_d   = llr_word;
            if (load_cnt_q == A_WID'(Z - 1)) begin
              state_d    = IDLE;
              load_cnt_d = '0;
              done_d     = 1'b1;
            end else begin
              load_cnt_d = load_cnt_q + 1'b1;
            end
          end
        end
        READ: begin
          if (rd_final) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and load-path registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      ram_wr     <= 1'b0;
      wr_addr    <= '0;
      ram_d      <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      ram_wr     <= ram_wr_d;
      wr_addr    <= wr_addr_d;
      ram_d      <= ram_d_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_vtc_cell_qc.sv
// Testbench for vtc_cell_qc: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the cell.
module tb_vtc_cell_qc;

  localparam int D_WID = 8;
  localparam int A_WID = 8;
  localparam int Z     = 8;
  localparam int NE    = 3;
  localparam logic [NE*A_WID-1:0] OFF0 = {8'd7, 8'd3, 8'd0};
  localparam logic [NE*A_WID-1:0] OFF1 = {8'd5, 8'd2, 8'd1};
`ifdef VTC_SAT_EN
  localparam int IW = D_WID + 2;
`else
  localparam int IW = D_WID;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rate = 1'b0, load_start = 1'b0, read_start = 1'b0, abort = 1'b0;
  logic llr_valid = 1'b0, rd_stall = 1'b0;
  logic [IW-1:0] llr_data = '0;
  logic llr_ready, ram_wr, rd_en, rd_last, busy, done;
  logic [A_WID-1:0] wr_addr, rd_addr;
  logic [D_WID-1:0] ram_d;
  logic [3:0] rd_edge;

  vtc_cell_qc #(
    .D_WID(D_WID), .A_WID(A_WID), .Z(Z), .NUM_EDGES(NE),
    .OFFSETS_R0(OFF0), .OFFSETS_R1(OFF1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rate(rate), .load_start(load_start),
    .read_start(read_start), .abort(abort), .llr_valid(llr_valid),
    .llr_ready(llr_ready), .llr_data(llr_data), .ram_wr(ram_wr),
    .wr_addr(wr_addr), .ram_d(ram_d), .rd_stall(rd_stall), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_edge(rd_edge), .rd_last(rd_last), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int off_t [2][NE] = '{'{0, 3, 7}, '{1, 2, 5}};
  int m_mode, m_cnt, m_rate;   // mode: 0 idle, 1 loading, 2 reading; m_cnt = beats/reads done
  logic e_wr, e_rden, e_last, e_done;
  logic [7:0] e_waddr, e_wdata, e_raddr;
  logic [3:0] e_edge;

  function automatic logic [7:0] model_data(input logic [IW-1:0] d);
`ifdef VTC_SAT_EN
    int v;
    v = int'($signed(d));
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
`else
    return d;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0; m_cnt <= 0; m_rate <= 0;
      e_wr <= 0; e_rden <= 0; e_last <= 0; e_done <= 0;
      e_waddr <= 0; e_wdata <= 0; e_raddr <= 0; e_edge <= 0;
    end else begin
      e_wr <= 0; e_rden <= 0; e_last <= 0; e_done <= e_last;
      if (abort) begin
        m_mode <= 0; m_cnt <= 0; e_done <= 0;
        e_waddr <= 0; e_wdata <= 0; e_raddr <= 0; e_edge <= 0;
      end else if (m_mode == 0) begin
        if (load_start) begin m_mode <= 1; m_cnt <= 0; end
        else if (read_start) begin m_mode <= 2; m_cnt <= 0; m_rate <= int'(rate); end
      end else if (m_mode == 1) begin
        if (llr_valid) begin
          e_wr <= 1; e_waddr <= 8'(m_cnt); e_wdata <= model_data(llr_data);
          m_cnt <= m_cnt + 1;
          if (m_cnt == Z - 1) begin m_mode <= 0; e_done <= 1; end
        end
      end else begin
        if (!rd_stall) begin
          e_rden  <= 1;
          e_edge  <= 4'(m_cnt / Z);
          e_raddr <= 8'(((m_cnt % Z) + off_t[m_rate][m_cnt / Z]) % Z);
          e_last  <= (m_cnt == Z * NE - 1);
          m_cnt   <= m_cnt + 1;
          if (m_cnt == Z * NE - 1) m_mode <= 0;
        end
      end
    end
  end

  // ---------------- compare process and transaction log ----------------
  int cyc = 0;
  int wr_n = 0, rd_n = 0, done_n = 0;
  int wr_cyc = 0, last_cyc = 0, done_cyc = 0, first_rd_cyc = 0;
  logic [7:0] wr_d [1024];
  logic [7:0] wr_a [1024];
  logic [7:0] rd_a [1024];
  logic [3:0] rd_e [1024];
  int rd_cyc [1024];

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("ram_wr", ram_wr, e_wr);
    chk("wr_addr", wr_addr, e_waddr);
    chk("ram_d", ram_d, e_wdata);
    chk("rd_en", rd_en, e_rden);
    chk("rd_addr", rd_addr, e_raddr);
    chk("rd_edge", rd_edge, e_edge);
    chk("rd_last", rd_last, e_last);
    chk("done", done, e_done);
    chk("busy", busy, m_mode != 0);
    chk("llr_ready", llr_ready, m_mode == 1);
    chk("wr_rd_excl", ram_wr & rd_en, 0);
    if (ram_wr) begin
      $display("wr  addr=%0d data=%02h", wr_addr, ram_d);
      wr_a[wr_n % 1024] = wr_addr; wr_d[wr_n % 1024] = ram_d; wr_n++; wr_cyc = cyc;
    end
    if (rd_en) begin
      $display("rd  edge=%0d addr=%0d last=%0d", rd_edge, rd_addr, rd_last);
      rd_a[rd_n % 1024] = rd_addr; rd_e[rd_n % 1024] = rd_edge; rd_cyc[rd_n % 1024] = cyc; rd_n++;
    end
    if (rd_last) last_cyc = cyc;
    if (done) begin done_n++; done_cyc = cyc; end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int pat, input int vals [Z]);
    int k, n;
    logic rdy;
    k = 0; n = 0;
    load_start = 1; step(); load_start = 0;
    while (k < Z && n < 100) begin
      llr_valid = (pat == 0) ? 1'b1 : ((n % 2) == 0);
      llr_data  = IW'(vals[k]);
      rdy = llr_ready;
      step();
      if (llr_valid && rdy) k++;
      n++;
    end
    llr_valid = 0;
    chk("load_beats_within_budget", k, Z);
    step(); step();
  endtask

  task automatic do_read(input logic r, input int stall_at, input int stall_len, input int abort_at);
    int base, n, sl;
    base = rd_n; n = 0; sl = 0;
    rate = r; read_start = 1; step(); read_start = 0;
    while (n < 200) begin
      rd_stall = (stall_at >= 0) && (rd_n - base >= stall_at) && (sl < stall_len);
      if (rd_stall) sl++;
      if (abort_at >= 0 && rd_n - base == abort_at) begin
        abort = 1; step(); abort = 0; break;
      end
      step();
      n++;
      if (!busy) break;
    end
    rd_stall = 0;
    chk("read_within_budget", n < 200, 1);
    step(); step();
  endtask

  int exp_r0 [24] = '{0,1,2,3,4,5,6,7, 3,4,5,6,7,0,1,2, 7,0,1,2,3,4,5,6};
  int exp_r1e1 [8] = '{2,3,4,5,6,7,0,1};
  int seq_vals [Z] = '{'h10,'h11,'h12,'h13,'h14,'h15,'h16,'h17};

  initial begin
    int b, d0;
    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_ready", llr_ready, 0);
    chk("rst_rd_en", rd_en, 0);
    reset_n = 1;
    step();

    // Load, continuous valid
    b = wr_n;
    do_load(0, seq_vals);
    chk("load_count", wr_n - b, 8);
    chk("load_first_addr", wr_a[b], 0);
    chk("load_last_addr", wr_a[b + 7], 7);
    chk("load_last_data", wr_d[b + 7], 8'h17);
    chk("load_done_with_last_wr", done_cyc, wr_cyc);
    chk("load_ready_dropped", llr_ready, 0);

    // Load with bubbles
    b = wr_n;
    do_load(1, seq_vals);
    chk("bubble_count", wr_n - b, 8);
    for (int i = 0; i < 8; i++) chk("bubble_addr", wr_a[b + i], i);

    // Read rate 0
    b = rd_n;
    do_read(0, -1, 0, -1);
    chk("r0_count", rd_n - b, 24);
    for (int i = 0; i < 24; i++) chk("r0_addr", rd_a[b + i], exp_r0[i]);
    chk("r0_edge1", rd_e[b + 8], 1);
    chk("r0_edge2", rd_e[b + 16], 2);
    chk("r0_last_on_24th", last_cyc, rd_cyc[b + 23]);
    chk("r0_done_after_last", done_cyc - last_cyc, 1);

    // Read rate 1 with a 3-cycle stall inside edge 1
    b = rd_n;
    do_read(1, 10, 3, -1);
    chk("r1_count", rd_n - b, 24);
    for (int i = 0; i < 8; i++) chk("r1_edge1_addr", rd_a[b + 8 + i], exp_r1e1[i]);
    chk("r1_stall_span", rd_cyc[b + 23] - rd_cyc[b], 26);

    // Abort mid-read, then restart
    d0 = done_n;
    do_read(0, -1, 0, 10);
    step(); step();
    chk("abort_no_done", done_n - d0, 0);
    chk("abort_idle", busy, 0);
    b = rd_n;
    do_read(0, -1, 0, -1);
    chk("restart_addr0", rd_a[b], 0);
    chk("restart_edge0", rd_e[b], 0);
    chk("restart_count", rd_n - b, 24);

    // Reset asserted mid-load
    load_start = 1; step(); load_start = 0;
    llr_valid = 1; llr_data = IW'(8'h55);
    step(); step(); step();
    llr_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", llr_ready, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_ram_d", ram_d, 0);
    step();
    reset_n = 1;
    step();

`ifdef VTC_SAT_EN
    begin
      int sv [Z] = '{200, -300, 5, 0, 0, 0, 0, 0};
      b = wr_n;
      do_load(0, sv);
      chk("sat_pos", wr_d[b], 8'd127);
      chk("sat_neg", wr_d[b + 1], 8'h80);
      chk("sat_pass", wr_d[b + 2], 8'd5);
    end
`endif

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int n;
      rate = 1'($urandom);
      load_start = ($urandom_range(0, 1) == 0);
      read_start = 1'($urandom);
      step();
      load_start = 0; read_start = 0;
      n = 0;
      while (m_mode != 0 && n < 300) begin
        llr_valid = 1'($urandom);
        llr_data  = IW'($urandom);
        rd_stall  = ($urandom_range(0, 3) == 0);
        abort     = ($urandom_range(0, 63) == 0);
        load_start = ($urandom_range(0, 15) == 0);
        read_start = ($urandom_range(0, 15) == 0);
        rate = 1'($urandom);
        step();
        n++;
      end
      llr_valid = 1; rd_stall = 0; abort = 0; load_start = 0; read_start = 0;
      for (int w = 0; w < 100 && m_mode != 0; w++) step();
      llr_valid = 0;
      step();
      chk("rand_returns_idle", busy, 0);
    end

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vtc_cell_qc.md
Name: vtc_cell_qc

Overview:
- Parametrised successor of the variable-to-check LLR cell for QC-LDPC decoding.
- Phase 1 (LOAD): accepts a stream of channel LLRs over a valid/ready handshake and writes them into the variable-node RAM at addresses 0..Z-1.
- Phase 2 (READ): generates circularly shifted read addresses for NUM_EDGES circulant edges. Each edge has an offset selected by the rate mode, and every read address is wrapped modulo Z.
- Sits between the channel LLR front-end / RAM and the check-node pipeline. Owns its own FSM instead of taking an external fsm/cycle code.

Parameters:
- D_WID, 8, LLR width written to RAM.
- A_WID, 8, RAM address width; 2^A_WID >= Z.
- Z, 64, circulant size (RAM depth used); 2 <= Z <= 2^A_WID.
- NUM_EDGES, 4, number of circulant edges read per iteration; 1..16.
- OFFSETS_R0, 0, packed NUM_EDGES*A_WID vector of edge offsets for rate=0. Edge e is at bits [e*A_WID +: A_WID]. Each offset < Z.
- OFFSETS_R1, 0, the same, for rate=1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- rate  in  1  offset table select; sampled at read_start
- load_start  in  1  pulse: IDLE->LOAD
- read_start  in  1  pulse: IDLE->READ
- abort  in  1  synchronous return to IDLE from any state
- llr_valid  in  1  LLR beat valid
- llr_ready  out  1  high only in LOAD
- llr_data  in  D_WID (D_WID+2 with VTC_SAT_EN)  LLR beat
- ram_wr  out  1  RAM write strobe
- wr_addr  out  A_WID  RAM write address
- ram_d  out  D_WID  RAM write data
- rd_stall  in  1  downstream back-pressure; freezes READ
- rd_en  out  1  RAM read strobe
- rd_addr  out  A_WID  RAM read address
- rd_edge  out  4  edge index of the current read
- rd_last  out  1  high with the final read of the iteration
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on LOAD or READ completion

Behaviour:
- Reset: state IDLE. All outputs 0, including llr_ready, ram_wr, wr_addr, ram_d, rd_en, rd_addr, rd_edge, rd_last, busy, done. Internal counters are cleared.
- FSM states: IDLE, LOAD, READ.
  - IDLE->LOAD on load_start.
  - IDLE->READ on read_start; load_start has priority if both are asserted.
  - Start pulses outside IDLE are ignored.
  - abort has the highest priority. Next cycle: IDLE, counters cleared, registered outputs 0, and no done pulse.
- LOAD:
  - llr_ready=1 in every LOAD cycle.
  - An accepted beat (llr_valid & llr_ready) registers ram_wr=1, wr_addr=load count, ram_d=data, all one cycle later.
  - Non-accepted cycles register ram_wr=0; wr_addr and ram_d hold.
  - The load counter runs 0..Z-1. On the Z-th accepted beat the FSM moves to IDLE and done pulses in the same cycle as the final ram_wr.
  - llr_ready=0 from the cycle after the Z-th accept.
- READ:
  - rate is latched at read_start. Counters are c (0..Z-1, inner) and e (0..NUM_EDGES-1, outer).
  - Each non-stalled cycle registers rd_en=1, rd_edge=e, and rd_addr=(c+OFF[e]) mod Z.
  - The sum is computed A_WID+1 bits wide; Z is subtracted once if sum >= Z.
  - c wraps Z-1->0 and then e increments.
  - When rd_stall=1: rd_en=0 next cycle, counters hold, rd_addr/rd_edge hold.
  - rd_last=1 with the read e=NUM_EDGES-1, c=Z-1. Next state IDLE; done pulses the cycle after rd_last.
  - Total non-stalled read cycles = NUM_EDGES*Z. First rd_en occurs 1 cycle after read_start.
- ram_wr and rd_en are never high simultaneously.
- Elaboration checks: offset >= Z, Z > 2^A_WID, or NUM_EDGES > 16 is a fatal error.

Optional Feature:
- Macro VTC_SAT_EN.
- Defined: llr_data is D_WID+2 bits, signed. It is saturated to the signed D_WID range before registering into ram_d. Example for D_WID=8: +200 -> 127, -300 -> -128. Adds no latency.
- Undefined: llr_data is D_WID bits and passes through unchanged.

Decomposition:
- Package vtc_pkg holds:
  - state enum (IDLE, LOAD, READ);
  - localparam function clog2;
  - function mod_add(c, off, Z) returning the wrapped address;
  - function sat_llr for the saturation path.
- One sub-module, vtc_rd_agen: the READ address generator. It contains the c/e counters, offset mux by latched rate, modulo add, and rd_last/stall logic.
- The top contains the FSM, the load path and the saturation path.

Test Plan:
Common configuration for all scenarios: Z=8, NUM_EDGES=3, OFFSETS_R0={0,3,7}, OFFSETS_R1={1,2,5}.
- Load: load_start, then 8 beats with data 0x10..0x17 on continuous llr_valid -> ram_wr at wr_addr 0..7 carrying 0x10..0x17; done with the last write; llr_ready drops.
- Load bubbles: llr_valid toggled 1,0,1,0 -> ram_wr only on accepted beats, wr_addr contiguous 0..7, exactly 8 writes.
- Read rate0: read_start with rate=0 -> 24 reads.
  - Edge 0 addrs 0..7; edge 1 addrs 3,4,5,6,7,0,1,2; edge 2 addrs 7,0..6.
  - rd_last on the 24th read; done one cycle later.
- Read rate1 with stalls: rd_stall high for 3 cycles mid edge 1 -> rd_en low for 3 cycles, address sequence unchanged (edge 1 = 2..7,0,1), total 24 reads.
- Abort and reset: abort at read 10 -> IDLE next cycle, no done, next read_start restarts at edge 0 addr 0. Asserting reset_n low mid-LOAD -> all outputs 0 immediately.
- VTC_SAT_EN: inputs +200, -300, +5 -> ram_d 127, -128, 5.
